// File: rtl/tt_um_hoene_line_pkg.sv
// Shared encodings for the hoene line encoder: line-code modes, FSM states
// and the first-half-bit level function.
package tt_um_hoene_line_pkg;

  localparam logic [1:0] MODE_NRZ    = 2'd0;
  localparam logic [1:0] MODE_THOMAS = 2'd1;
  localparam logic [1:0] MODE_IEEE   = 2'd2;
  localparam logic [1:0] MODE_DIFF   = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  // Level of the first half of a bit; prev is the level of the half-bit before it.
  function automatic logic first_level(input logic [1:0] mode, input logic b, input logic prev);
    case (mode)
      MODE_NRZ, MODE_THOMAS: return b;
      MODE_IEEE:             return ~b;
      default:               return prev ^ ~b;
    endcase
  endfunction

endpackage

// File: rtl/tt_um_hoene_halfbit_timer.sv
// Half-bit countdown: loads a length, counts down to zero and holds there;
// expire is high while the count is zero.
module tt_um_hoene_halfbit_timer #(
  parameter int unsigned PW_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PW_W-1:0] value,
  output logic            expire
);

  logic [PW_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - PW_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/tt_um_hoene_line_encoder.sv
// Serial line encoder: sends DATA_W-bit words MSB first as NRZ, Manchester
// (Thomas / IEEE) or differential Manchester with a programmable half-bit length.
module tt_um_hoene_line_encoder
  import tt_um_hoene_line_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PW_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_word,
  input  logic [1:0]        in_mode,
  input  logic [PW_W-1:0]   in_halfbit,
  output logic              out_data,
  output logic              out_enable,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DATA_W) + 1;

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] shift_q, shift_nx, shifted;
  logic [1:0]        mode_q, mode_nx;
  logic [PW_W-1:0]   hb_q, hb_nx;
  logic [IDX_W-1:0]  idx_q, idx_nx;
  logic              data_nx, en_nx, busy_nx;
  logic              ready_en;
  logic              accept;
  logic              load;
  logic [PW_W-1:0]   load_value;
  logic              expire;

  tt_um_hoene_halfbit_timer #(.PW_W(PW_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .value  (load_value),
    .expire (expire)
  );

  // ready_en keeps in_ready low until the first cycle after reset is released
  assign in_ready = ready_en & ((state == ST_IDLE) |
                               ((state == ST_SECOND) & (idx_q == '0) & expire));
  assign accept   = in_valid & in_ready;
  assign shifted  = shift_q << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      mode_q     <= MODE_NRZ;
      hb_q       <= '0;
      idx_q      <= '0;
      out_data   <= 1'b0;
      out_enable <= 1'b0;
      busy       <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_nx;
      shift_q    <= shift_nx;
      mode_q     <= mode_nx;
      hb_q       <= hb_nx;
      idx_q      <= idx_nx;
      out_data   <= data_nx;
      out_enable <= en_nx;
      busy       <= busy_nx;
      ready_en   <= 1'b1;
    end
  end

  // Next state and next line level; out_data doubles as the previous half-bit level
  always_comb begin
    state_nx   = state;
    shift_nx   = shift_q;
    mode_nx    = mode_q;
    hb_nx      = hb_q;
    idx_nx     = idx_q;
    data_nx    = out_data;
    en_nx      = out_enable;
    busy_nx    = busy;
    load       = 1'b0;
    load_value = hb_q;
    if (accept) begin
      state_nx   = ST_FIRST;
      shift_nx   = in_word;
      mode_nx    = in_mode;
      hb_nx      = in_halfbit;
      idx_nx     = IDX_W'(DATA_W - 1);
      data_nx    = first_level(in_mode, in_word[DATA_W-1], out_data);
      en_nx      = 1'b1;
      busy_nx    = 1'b1;
      load       = 1'b1;
      load_value = in_halfbit;
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_FIRST: begin
          if (expire) begin
            state_nx = ST_SECOND;
            data_nx  = (mode_q == MODE_NRZ) ? out_data : ~out_data;
            load     = 1'b1;
          end
        end
        ST_SECOND: begin
          if (expire) begin
            if (idx_q != '0) begin
              state_nx = ST_FIRST;
              shift_nx = shifted;
              idx_nx   = idx_q - IDX_W'(1);
              data_nx  = first_level(mode_q, shifted[DATA_W-1], out_data);
              load     = 1'b1;
            end else begin
              state_nx = ST_IDLE;
              data_nx  = 1'b0;
              en_nx    = 1'b0;
              busy_nx  = 1'b0;
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          data_nx  = 1'b0;
          en_nx    = 1'b0;
          busy_nx  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_line_encoder.sv
// Directed bench for tt_um_hoene_line_encoder (DATA_W=8): line patterns per mode,
// timing, back-to-back handoff, mid-word input changes and reset abort.
module tb_tt_um_hoene_line_encoder;
  import tt_um_hoene_line_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_word = 8'h00;
  logic [1:0] in_mode = MODE_NRZ;
  logic [5:0] in_halfbit = 6'd0;
  logic       out_data;
  logic       out_enable;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] data;
  int en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy;

  always #5 clk = ~clk;

  tt_um_hoene_line_encoder #(.DATA_W(8), .PW_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_mode    (in_mode),
    .in_halfbit (in_halfbit),
    .out_data   (out_data),
    .out_enable (out_enable),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer a word and wait (bounded) for the accepting edge.
  task automatic offer(input logic [7:0] w, input logic [1:0] m, input logic [5:0] hb,
                       input bit keep);
    int n = 0;
    @(negedge clk);
    in_word = w; in_mode = m; in_halfbit = hb; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Sample n cycles; collect enabled line bits, drop in_valid after any accept,
  // and at cycle chg_at re-drive the inputs with a new word offer.
  task automatic monitor(input int n, input int chg_at, input logic [7:0] nw,
                         input logic [1:0] nm, input logic [5:0] nh,
                         output logic [63:0] d, output int en, output int bz,
                         output int rdy, output int off, output int frdy);
    bit drop = 1'b0;
    d = '0; en = 0; bz = 0; rdy = 0; off = -1; frdy = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (drop) begin
        in_valid = 1'b0;
        drop = 1'b0;
      end
      if (busy) bz++;
      if (out_enable) begin
        d = {d[62:0], out_data};
        en++;
        if (in_ready) begin
          rdy++;
          if (frdy < 0) frdy = i;
        end
      end else if (off < 0) begin
        off = i;
      end
      if (in_ready && in_valid) drop = 1'b1;
      if (i == chg_at) begin
        in_word = nw; in_mode = nm; in_halfbit = nh; in_valid = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_enable", 64'(out_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Thomas, halfbit 0, A5
    offer(8'hA5, MODE_THOMAS, 6'd0, 1'b0);
    monitor(18, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("thomas_data", data, 64'h9966);
    check("thomas_en", 64'(en_cnt), 64'd16);
    check("thomas_off", 64'(first_off), 64'd16);
    check("thomas_rdy_cnt", 64'(rdy_cnt), 64'd1);
    check("thomas_rdy_at", 64'(first_rdy), 64'd15);
    check("idle_data", 64'(out_data), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // IEEE, halfbit 0, A5
    offer(8'hA5, MODE_IEEE, 6'd0, 1'b0);
    monitor(18, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("ieee_data", data, 64'h6699);
    check("ieee_off", 64'(first_off), 64'd16);

    // Differential, FF from idle
    offer(8'hFF, MODE_DIFF, 6'd0, 1'b0);
    monitor(18, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("diff_data", data, 64'h6666);
    check("diff_en", 64'(en_cnt), 64'd16);

    // NRZ, halfbit 2, 80: six ones then 42 zeros
    offer(8'h80, MODE_NRZ, 6'd2, 1'b0);
    monitor(50, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("nrz_data", data, 64'h0000_FC00_0000_0000);
    check("nrz_en", 64'(en_cnt), 64'd48);
    check("nrz_busy", 64'(busy_cnt), 64'd48);
    check("nrz_off", 64'(first_off), 64'd48);

    // Back-to-back, Thomas halfbit 1: 01 then FE with in_valid held
    offer(8'h01, MODE_THOMAS, 6'd1, 1'b1);
    in_word = 8'hFE;
    monitor(70, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("b2b_data", data, 64'h3333_333C_CCCC_CCC3);
    check("b2b_en", 64'(en_cnt), 64'd64);
    check("b2b_off", 64'(first_off), 64'd64);
    check("b2b_rdy_at", 64'(first_rdy), 64'd31);
    check("b2b_rdy_cnt", 64'(rdy_cnt), 64'd2);

    // Mid-word input changes: current word unaffected, held offer uses new values
    offer(8'hA5, MODE_THOMAS, 6'd0, 1'b0);
    monitor(52, 2, 8'hA5, MODE_IEEE, 6'd1, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("chg_data", data, 64'h0000_9966_3C3C_C3C3);
    check("chg_en", 64'(en_cnt), 64'd48);
    check("chg_rdy_at", 64'(first_rdy), 64'd15);

    // Reset during cycle 5 of a word
    offer(8'hA5, MODE_THOMAS, 6'd0, 1'b0);
    monitor(4, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("abort_pre_data", data, 64'h9);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_enable", 64'(out_enable), 64'd0);
    check("abort_data", 64'(out_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_rise", 64'(in_ready), 64'd1);
    offer(8'hA5, MODE_IEEE, 6'd0, 1'b0);
    monitor(18, -1, 8'h00, MODE_NRZ, 6'd0, data, en_cnt, busy_cnt, rdy_cnt, first_off, first_rdy);
    check("post_rst_data", data, 64'h6699);
    check("post_rst_off", 64'(first_off), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_line_encoder.md
TT_UM_HOENE_LINE_ENCODER -- requirements
Module: tt_um_hoene_line_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bits per word, range 1..32, sent MSB first.
REQ-002 SHALL have parameter PW_W, default 6: width of the half-bit duration input.
REQ-003 clk  input  1  global clock; the only clock.
REQ-004 rst_n  input  1  device reset, synchronous, active-low.
REQ-005 in_valid  input  1  word offered.
REQ-006 in_ready  output  1  word accepted on a clk edge where in_valid and in_ready are both 1.
REQ-007 in_word  input  DATA_W  word to encode.
REQ-008 in_mode  input  2  line code: 0 NRZ, 1 Manchester-Thomas, 2 Manchester-IEEE, 3 differential Manchester.
REQ-009 in_halfbit  input  PW_W  half-bit length; each half-bit lasts in_halfbit+1 clk cycles.
REQ-010 out_data  output  1  encoded line level.
REQ-011 out_enable  output  1  line driver enable.
REQ-012 busy  output  1  high while a word is being sent.

Function
REQ-013 SHALL implement states IDLE, FIRST_HALF and SECOND_HALF.
REQ-014 SHALL, on accept, latch in_word, in_mode and in_halfbit; changes to these inputs mid-word SHALL have no effect.
REQ-015 SHALL, on accept at edge T, drive the first half-bit of the MSB on out_data from T+1, with out_enable=1 and busy=1 (latency 1 cycle).
REQ-016 Half-bit timer: SHALL load in_halfbit, count down to 0, then advance FIRST_HALF->SECOND_HALF, or SECOND_HALF->FIRST_HALF of the next bit.
REQ-017 SHALL, with in_halfbit=0, make each half-bit exactly 1 cycle long.
REQ-018 Bit encodings (first half, second half):
- NRZ: (b, b).
- Thomas: (b, ~b).
- IEEE: (~b, b).
- Differential: first = prev_level XOR ~b, second = ~first. prev_level is the level of the preceding half-bit, or 0 when starting from IDLE.
REQ-019 Word duration SHALL be exactly DATA_W*2*(in_halfbit+1) cycles.
REQ-020 in_ready SHALL be 1 in IDLE and in the final cycle of the last bit's SECOND_HALF; otherwise 0.
REQ-021 Back-to-back: if a word is accepted in that final cycle, the next word's first half-bit SHALL start on the following cycle, with no gap and out_enable held at 1.
REQ-022 SHALL, if no word is accepted in that final cycle, enter IDLE on the next cycle: out_enable=0, out_data=0, busy=0.
REQ-023 in_valid while in_ready=0 SHALL be ignored, and the word SHALL NOT be lost; the sender holds it until accepted.
REQ-024 in_mode and in_halfbit SHALL be sampled only on accept.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, out_data=0, out_enable=0, busy=0, in_ready=0, timer=0 and prev_level=0.
REQ-026 Reset mid-word SHALL abort the word with no completion; in_ready SHALL rise on the first cycle after rst_n returns to 1.

Structure
REQ-027 Shared package tt_um_hoene_line_pkg SHALL hold the mode encodings (MODE_NRZ, MODE_THOMAS, MODE_IEEE, MODE_DIFF) and the state encodings.
REQ-028 Half-bit countdown SHALL be a sub-module, tt_um_hoene_halfbit_timer (parameter PW_W; ports load, value, expire).
REQ-029 The bit index counter SHALL be $clog2(DATA_W)+1 bits wide, with no wrap ambiguity at DATA_W=32.

Verification (DATA_W=8)
REQ-030 Thomas, halfbit=0, word 8'hA5 -> out_data 1001100101100110 over 16 cycles, out_enable=1 throughout, then 0.
REQ-031 IEEE, halfbit=0, word 8'hA5 -> out_data 0110011010011001; differential, word 8'hFF from IDLE -> 0110011001100110.
REQ-032 NRZ, halfbit=2, word 8'h80 -> out_data 1 for 6 cycles, then 0 for 42 cycles; busy for exactly 48 cycles.
REQ-033 in_valid held high, words 8'h01 then 8'hFE, Thomas, halfbit=1 -> in_ready pulses 1 cycle at the end of word 1; 64 contiguous out_enable cycles.
REQ-034 Change in_mode and in_halfbit mid-word -> current word unchanged; the next word uses the new values.
REQ-035 rst_n=0 at cycle 5 of a word -> next cycle out_enable=0, out_data=0, busy=0; a new word after release encodes correctly.
